ntt_address_generator: RTL and testbench
========================================

NTT_ADDRESS_GENERATOR -- requirements
Module: ntt_address_generator

Interface
REQ-001 SHALL have no parameters; all sizes come from ntt_pkg (N=1024, LOG_N=10, NUM_BFU=8, NUM_PORT=16, ADDR_W=10).
REQ-002 SHALL have these ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a full 10-stage address sweep.
- stall  input  1  freezes issue while high.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last address group is issued.
- addr_valid  output  1  old_address_0..15 and stage_out carry a new group this cycle.
- stage_out  output  4  stage index of the current group, 0..9.
- old_address_0 .. old_address_15  output  10 each  port 2k = lower butterfly operand of BFU k, port 2k+1 = upper operand; feeds conflict_free_memory_map.

Function
REQ-003 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-004 In IDLE with start=1, SHALL clear stage counter s and cycle counter c (6 bit, 0..63) and enter RUN; start outside IDLE SHALL be ignored.
REQ-005 On each edge in RUN, addr_valid SHALL be registered as (stall==0).
REQ-006 When stall==0 in RUN, SHALL register one group for (s,c) and advance c; on c==63, SHALL wrap c to 0 and increment s.
REQ-007 Butterfly index for BFU k SHALL be j = c*8 + k (9 bits); distance exponent e = 9 - s (forward order).
REQ-008 Lower address SHALL be j with a 0 inserted at bit e (bits above e shift up one); upper address SHALL be lower + 2^e, with no carry possible.
REQ-009 While stall==1, counters and all output registers SHALL hold and addr_valid SHALL be 0.
REQ-010 After the group (s=9, c=63) is issued, SHALL enter DONE; DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-011 Latency: start at edge T SHALL produce the first addr_valid at edge T+2 if stall stays low; an unstalled sweep SHALL give exactly 640 valid cycles.
REQ-012 Outside RUN, address and stage outputs SHALL hold their last value with addr_valid=0.
REQ-013 Within one group, the 16 addresses SHALL be distinct.

Reset
REQ-014 On rst=1, SHALL enter IDLE immediately, including mid-sweep, and clear s and c.
REQ-015 All outputs SHALL reset to 0: busy, done, addr_valid, stage_out, and old_address_0..15.
REQ-016 An aborted sweep SHALL NOT resume; a new start is required.

Configuration
REQ-017 Macro NTT_AGEN_INTT_EN SHALL gate the inverse-order feature.
REQ-018 With NTT_AGEN_INTT_EN defined, SHALL add input port "inverse" (1 bit), sampled only when start is accepted:
- inverse=1: e = s (distances 1,2,...,512).
- inverse=0: forward order.
REQ-019 Without NTT_AGEN_INTT_EN, the inverse port SHALL be absent and only forward order SHALL exist.

Structure
REQ-020 ntt_pkg SHALL hold N, LOG_N, NUM_BFU, NUM_PORT, ADDR_W, the stage and cycle counter widths, and the FSM state enum.
REQ-021 Bit-insert and pair-address logic SHALL be one sub-module, pair_address_calc (inputs j, e; outputs lower, upper), instantiated 8 times.

Verification
REQ-022 Start with stall=0 -> first group stage_out=0, ports (0,512),(1,513)..(14 and 15 = 7,519); addr_valid at T+2.
REQ-023 Full sweep -> 640 addr_valid cycles, done high exactly once, 1 cycle after the last group; busy low afterwards.
REQ-024 Stage 1, c=32 -> port0=512, port1=768; stage 9, c=0 -> ports 0..15 = 0,1,2..15.
REQ-025 Stall held 5 cycles mid-stage 3 -> outputs frozen, addr_valid=0 for those 5 cycles, no group skipped or duplicated.
REQ-026 rst asserted at stage 4, then released, then start -> sweep restarts at stage 0, c=0; a start pulse during RUN has no effect.
REQ-027 With NTT_AGEN_INTT_EN and inverse=1 -> first group ports (0,1),(2,3)..(14,15) with stage_out=0; the final stage has distance 512.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared sizes, counter widths and FSM encoding for the NTT address generator.
package ntt_pkg;
  localparam int N        = 1024;
  localparam int LOG_N    = 10;
  localparam int NUM_BFU  = 8;
  localparam int NUM_PORT = 16;
  localparam int ADDR_W   = 10;
  localparam int STAGE_W  = 4;
  localparam int CYCLE_W  = 6;
  localparam int J_W      = 9;
  localparam int E_W      = 4;

  localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(N / (2 * NUM_BFU) - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG_N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/pair_address_calc.sv
// Maps butterfly index j and distance exponent e to the operand pair:
// lower = j with a zero inserted at bit e, upper = lower with bit e set.
module pair_address_calc
  import ntt_pkg::*;
(
  input  logic [J_W-1:0]    j,
  input  logic [E_W-1:0]    e,
  output logic [ADDR_W-1:0] lower,
  output logic [ADDR_W-1:0] upper
);

  logic [ADDR_W-1:0] j_ext;
  logic [ADDR_W-1:0] bit_e;
  logic [ADDR_W-1:0] mask;

  always_comb begin
    j_ext = {1'b0, j};
    bit_e = ADDR_W'(1) << e;
    mask  = bit_e - ADDR_W'(1);
    lower = ((j_ext & ~mask) << 1) | (j_ext & mask);
    upper = lower | bit_e;
  end

endmodule

// File: rtl/ntt_address_generator.sv
// Issues 16 butterfly operand addresses per cycle over a full 10-stage NTT sweep.
// Define NTT_AGEN_INTT_EN to add the "inverse" input selecting inverse stage order.
module ntt_address_generator
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
`ifdef NTT_AGEN_INTT_EN
  input  logic              inverse,
`endif
  output logic              busy,
  output logic              done,
  output logic              addr_valid,
  output logic [3:0]        stage_out,
  output logic [ADDR_W-1:0] old_address_0,
  output logic [ADDR_W-1:0] old_address_1,
  output logic [ADDR_W-1:0] old_address_2,
  output logic [ADDR_W-1:0] old_address_3,
  output logic [ADDR_W-1:0] old_address_4,
  output logic [ADDR_W-1:0] old_address_5,
  output logic [ADDR_W-1:0] old_address_6,
  output logic [ADDR_W-1:0] old_address_7,
  output logic [ADDR_W-1:0] old_address_8,
  output logic [ADDR_W-1:0] old_address_9,
  output logic [ADDR_W-1:0] old_address_10,
  output logic [ADDR_W-1:0] old_address_11,
  output logic [ADDR_W-1:0] old_address_12,
  output logic [ADDR_W-1:0] old_address_13,
  output logic [ADDR_W-1:0] old_address_14,
  output logic [ADDR_W-1:0] old_address_15
);

  state_t             state, next_state;
  logic [STAGE_W-1:0] s;
  logic [CYCLE_W-1:0] c;
  logic [E_W-1:0]     e;
  logic               accept, issue, last_group, busy_d, done_d;
  logic [ADDR_W-1:0]  lower [NUM_BFU];
  logic [ADDR_W-1:0]  upper [NUM_BFU];
  logic [ADDR_W-1:0]  addr_q [NUM_PORT];
  logic [3:0]         stage_q;
`ifdef NTT_AGEN_INTT_EN
  logic               inv_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  assign last_group = (s == LAST_STAGE) && (c == LAST_CYCLE);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (!stall && last_group) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // busy drops on the same edge that raises done, so the two never overlap
  always_comb begin
    accept = (state == ST_IDLE) && start;
    issue  = (state == ST_RUN) && !stall;
    busy_d = (next_state != ST_IDLE);
    done_d = (state == ST_DONE);
  end

  always_comb begin
`ifdef NTT_AGEN_INTT_EN
    e = inv_q ? E_W'(s) : E_W'(LAST_STAGE - s);
`else
    e = E_W'(LAST_STAGE - s);
`endif
  end

  for (genvar k = 0; k < NUM_BFU; k++) begin : g_bfu
    pair_address_calc u_pair (
      .j     ({c, 3'(k)}),
      .e     (e),
      .lower (lower[k]),
      .upper (upper[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s          <= '0;
      c          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_valid <= 1'b0;
`ifdef NTT_AGEN_INTT_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      addr_valid <= issue;
      if (accept) begin
        s <= '0;
        c <= '0;
`ifdef NTT_AGEN_INTT_EN
        inv_q <= inverse;
`endif
      end else if (issue) begin
        c <= c + CYCLE_W'(1);
        if (c == LAST_CYCLE) s <= s + STAGE_W'(1);
      end
    end
  end

  // Group registers: hold their last value whenever no group is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      for (int p = 0; p < NUM_PORT; p++) addr_q[p] <= '0;
    end else if (issue) begin
      stage_q <= s;
      for (int k = 0; k < NUM_BFU; k++) begin
        addr_q[2*k]   <= lower[k];
        addr_q[2*k+1] <= upper[k];
      end
    end
  end

  assign stage_out      = stage_q;
  assign old_address_0  = addr_q[0];
  assign old_address_1  = addr_q[1];
  assign old_address_2  = addr_q[2];
  assign old_address_3  = addr_q[3];
  assign old_address_4  = addr_q[4];
  assign old_address_5  = addr_q[5];
  assign old_address_6  = addr_q[6];
  assign old_address_7  = addr_q[7];
  assign old_address_8  = addr_q[8];
  assign old_address_9  = addr_q[9];
  assign old_address_10 = addr_q[10];
  assign old_address_11 = addr_q[11];
  assign old_address_12 = addr_q[12];
  assign old_address_13 = addr_q[13];
  assign old_address_14 = addr_q[14];
  assign old_address_15 = addr_q[15];

endmodule

// File: tb/tb_ntt_address_generator.sv
// Directed self-checking bench for ntt_address_generator (forward order, plus
// inverse order when NTT_AGEN_INTT_EN is defined).
module tb_ntt_address_generator;

  logic       clk = 1'b0;
  logic       rst, start, stall, inverse;
  logic       busy, done, addr_valid;
  logic [3:0] stage_out;
  logic [9:0] old_address_0, old_address_1, old_address_2, old_address_3;
  logic [9:0] old_address_4, old_address_5, old_address_6, old_address_7;
  logic [9:0] old_address_8, old_address_9, old_address_10, old_address_11;
  logic [9:0] old_address_12, old_address_13, old_address_14, old_address_15;
  logic [9:0] addrs [16];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ntt_address_generator dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stall          (stall),
`ifdef NTT_AGEN_INTT_EN
    .inverse        (inverse),
`endif
    .busy           (busy),
    .done           (done),
    .addr_valid     (addr_valid),
    .stage_out      (stage_out),
    .old_address_0  (old_address_0),
    .old_address_1  (old_address_1),
    .old_address_2  (old_address_2),
    .old_address_3  (old_address_3),
    .old_address_4  (old_address_4),
    .old_address_5  (old_address_5),
    .old_address_6  (old_address_6),
    .old_address_7  (old_address_7),
    .old_address_8  (old_address_8),
    .old_address_9  (old_address_9),
    .old_address_10 (old_address_10),
    .old_address_11 (old_address_11),
    .old_address_12 (old_address_12),
    .old_address_13 (old_address_13),
    .old_address_14 (old_address_14),
    .old_address_15 (old_address_15)
  );

  assign addrs[0]  = old_address_0;
  assign addrs[1]  = old_address_1;
  assign addrs[2]  = old_address_2;
  assign addrs[3]  = old_address_3;
  assign addrs[4]  = old_address_4;
  assign addrs[5]  = old_address_5;
  assign addrs[6]  = old_address_6;
  assign addrs[7]  = old_address_7;
  assign addrs[8]  = old_address_8;
  assign addrs[9]  = old_address_9;
  assign addrs[10] = old_address_10;
  assign addrs[11] = old_address_11;
  assign addrs[12] = old_address_12;
  assign addrs[13] = old_address_13;
  assign addrs[14] = old_address_14;
  assign addrs[15] = old_address_15;

  task automatic test_reset();
    int bad;
    rst = 1'b1; start = 1'b0; stall = 1'b0; inverse = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy, done, addr_valid} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_ctrl: busy/done/valid=%b required 000", {busy, done, addr_valid});
    end
    compared++;
    if (stage_out !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_stage: got %0d required 0", stage_out);
    end
    bad = -1;
    for (int p = 0; p < 16; p++) if (bad < 0 && addrs[p] !== 10'd0) bad = p;
    compared++;
    if (bad >= 0) begin
      mismatched++;
      $display("FAIL reset_addr: port %0d got %0d required 0", bad, addrs[bad]);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_group(input bit inv);
    int bad, exp_a;
    @(negedge clk);
    start = 1'b1; inverse = inv;
    @(negedge clk);
    start = 1'b0;
    compared++;
    if (busy !== 1'b1 || addr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL first_T1: busy=%b valid=%b required busy=1 valid=0", busy, addr_valid);
    end
    @(negedge clk);
    compared++;
    if (addr_valid !== 1'b1 || stage_out !== 4'd0) begin
      mismatched++;
      $display("FAIL first_T2: valid=%b stage=%0d required valid=1 stage=0", addr_valid, stage_out);
    end
    bad = -1; exp_a = 0;
    for (int p = 0; p < 16; p++) begin
      if (inv) exp_a = p;
      else     exp_a = (p % 2 == 0) ? p / 2 : p / 2 + 512;
      if (bad < 0 && addrs[p] !== 10'(exp_a)) begin
        bad = p;
        compared++; mismatched++;
        $display("FAIL first_group: port %0d got %0d required %0d", p, addrs[p], exp_a);
      end
    end
    if (bad < 0) compared++;
  endtask

  task automatic test_sweep(input bit inv, input bit do_stall);
    int es, ec, vcnt, dcnt, last_v, stall_left, e, pw, jj, lo, hi, bad, bad_exp;
    bit stalled, finished, dup;
    logic [9:0] snap [16];
    logic [3:0] snap_stage;
    es = 0; ec = 1; vcnt = 1; dcnt = 0; last_v = -1; stall_left = 0;
    stalled = 0; finished = 0; snap_stage = '0;
    for (int p = 0; p < 16; p++) snap[p] = '0;
    for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        compared++;
        if (addr_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL stall_valid: valid=%b required 0", addr_valid);
        end
        bad = -1;
        for (int p = 0; p < 16; p++) if (bad < 0 && addrs[p] !== snap[p]) bad = p;
        compared++;
        if (bad >= 0 || stage_out !== snap_stage) begin
          mismatched++;
          $display("FAIL stall_frozen: stage %0d/%0d port %0d changed", stage_out, snap_stage, bad);
        end
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end else if (addr_valid === 1'b1) begin
        e  = inv ? es : 9 - es;
        pw = 1 << e;
        compared++;
        if (stage_out !== 4'(es)) begin
          mismatched++;
          $display("FAIL sweep_stage: c=%0d got %0d required %0d", ec, stage_out, es);
        end
        bad = -1; bad_exp = 0;
        for (int k = 0; k < 8; k++) begin
          jj = ec * 8 + k;
          lo = (jj / pw) * (2 * pw) + jj % pw;
          hi = lo + pw;
          if (bad < 0 && addrs[2*k] !== 10'(lo)) begin bad = 2*k; bad_exp = lo; end
          if (bad < 0 && addrs[2*k+1] !== 10'(hi)) begin bad = 2*k+1; bad_exp = hi; end
        end
        compared++;
        if (bad >= 0) begin
          mismatched++;
          $display("FAIL sweep_addr: s=%0d c=%0d port %0d got %0d required %0d",
                   es, ec, bad, addrs[bad], bad_exp);
        end
        dup = 0;
        for (int p = 0; p < 16; p++)
          for (int q = p + 1; q < 16; q++) if (addrs[p] === addrs[q]) dup = 1;
        compared++;
        if (dup) begin
          mismatched++;
          $display("FAIL distinct: s=%0d c=%0d duplicate address in group, got dup=1 required 0", es, ec);
        end
        if (!inv && es == 1 && ec == 32) begin
          compared++;
          if (old_address_0 !== 10'd512 || old_address_1 !== 10'd768) begin
            mismatched++;
            $display("FAIL s1c32: got %0d,%0d required 512,768", old_address_0, old_address_1);
          end
        end
        if (!inv && es == 9 && ec == 0) begin
          bad = -1;
          for (int p = 0; p < 16; p++) if (bad < 0 && addrs[p] !== 10'(p)) bad = p;
          compared++;
          if (bad >= 0) begin
            mismatched++;
            $display("FAIL s9c0: port %0d got %0d required %0d", bad, addrs[bad], bad);
          end
        end
        if (inv && es == 9 && ec == 0) begin
          compared++;
          if (old_address_0 !== 10'd0 || old_address_1 !== 10'd512) begin
            mismatched++;
            $display("FAIL inv_last_stage: got %0d,%0d required 0,512", old_address_0, old_address_1);
          end
        end
        vcnt++;
        last_v = cyc;
        ec++;
        if (ec == 64) begin ec = 0; es++; end
      end
      if (done === 1'b1) begin
        dcnt++;
        finished = 1;
        compared++;
        if (cyc != last_v + 1) begin
          mismatched++;
          $display("FAIL done_timing: done at cycle %0d required %0d", cyc, last_v + 1);
        end
      end
      if (do_stall && !stalled && es == 3 && ec == 20) begin
        stall = 1'b1; stall_left = 5; stalled = 1;
        snap_stage = stage_out;
        for (int p = 0; p < 16; p++) snap[p] = addrs[p];
      end
    end
    compared++;
    if (!finished) begin
      mismatched++;
      $display("FAIL sweep_timeout: done not seen, got 0 required 1");
    end
    compared++;
    if (vcnt != 640) begin
      mismatched++;
      $display("FAIL valid_count: got %0d required 640", vcnt);
    end
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    compared++;
    if (dcnt != 1) begin
      mismatched++;
      $display("FAIL done_count: got %0d required 1", dcnt);
    end
    compared++;
    if (busy !== 1'b0 || addr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL after_done: busy=%b valid=%b required 0 0", busy, addr_valid);
    end
  endtask

  task automatic test_reset_abort();
    bit found;
    found = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (addr_valid === 1'b1 && stage_out === 4'd4) found = 1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL abort_reach_s4: got 0 required 1");
    end
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({busy, addr_valid, done} !== 3'b000 || stage_out !== 4'd0 || old_address_1 !== 10'd0) begin
      mismatched++;
      $display("FAIL abort_reset: busy/valid/done=%b stage=%0d a1=%0d required 000 0 0",
               {busy, addr_valid, done}, stage_out, old_address_1);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      compared++;
      if (addr_valid !== 1'b0 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL abort_no_resume: valid=%b busy=%b required 0 0", addr_valid, busy);
      end
    end
  endtask

  task automatic test_start_ignored();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    compared++;
    if (addr_valid !== 1'b1 || stage_out !== 4'd0 || old_address_0 !== 10'd0 || old_address_1 !== 10'd512) begin
      mismatched++;
      $display("FAIL restart_first: valid=%b stage=%0d a0=%0d a1=%0d required 1 0 0 512",
               addr_valid, stage_out, old_address_0, old_address_1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    compared++;
    if (addr_valid !== 1'b1 || old_address_0 !== 10'd8 || old_address_15 !== 10'd527) begin
      mismatched++;
      $display("FAIL start_in_run_c1: valid=%b a0=%0d a15=%0d required 1 8 527",
               addr_valid, old_address_0, old_address_15);
    end
    @(negedge clk);
    compared++;
    if (addr_valid !== 1'b1 || old_address_0 !== 10'd16 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL start_in_run_c2: valid=%b a0=%0d busy=%b required 1 16 1",
               addr_valid, old_address_0, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_first_group(1'b0);
    test_sweep(1'b0, 1'b1);
    test_reset_abort();
    test_start_ignored();
`ifdef NTT_AGEN_INTT_EN
    test_first_group(1'b1);
    test_sweep(1'b1, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
